filtered_edge_detector: RTL and testbench
=========================================

# filtered_edge_detector

Multi-channel, parametrised edge detector with per-channel glitch filtering and selectable edge polarity. Each of WIDTH independent inputs is tracked by a filtered level register. A transition is accepted only after the input has differed from that register for FILTER_DEPTH consecutive clock samples. Sits after synchronisers on slow control/status lines (buttons, interrupts, handshake strobes) and feeds single-cycle event pulses to counters and controllers. With WIDTH=1, FILTER_DEPTH=1 and EDGE_MODE=2 it is cycle-equivalent to the single-channel any-edge detector.

## Interface
- WIDTH, 1, number of independent channels (≥1).
- FILTER_DEPTH, 1, consecutive differing samples required to accept a transition (≥1; 1 = no filtering).
- EDGE_MODE, 2, edge_pulse selection: 0 = rising only, 1 = falling only, 2 = both.
- RESET_LEVEL, 0, 1-bit value loaded into every channel's filtered level at reset.

Ports:
- clock  input  1  single clock; everything samples on the rising edge.
- reset  input  1  synchronous, active-high reset.
- signal  input  WIDTH  raw channel inputs, already synchronous to clock.
- level  output  WIDTH  filtered level per channel (registered).
- rising_pulse  output  WIDTH  accepted 0→1 transition, one cycle.
- falling_pulse  output  WIDTH  accepted 1→0 transition, one cycle.
- edge_pulse  output  WIDTH  rising_pulse and/or falling_pulse, chosen by EDGE_MODE.

## Operation
- Per-channel state:
  - L, the filtered level register, 1 bit.
  - C, the stability counter, width $clog2(FILTER_DEPTH) (minimum 1).
- Combinational accept term: accept[i] = (signal[i] != L[i]) && (C[i] == FILTER_DEPTH-1) && !reset.
- Pulse outputs:
  - rising_pulse[i] = accept[i] && signal[i].
  - falling_pulse[i] = accept[i] && !signal[i].
  - edge_pulse per EDGE_MODE. Invalid EDGE_MODE values behave as 2.
- Sequential update per channel, each rising clock edge:
  - reset=1: L ← RESET_LEVEL, C ← 0.
  - accept: L ← signal, C ← 0.
  - signal != L and not accept: C ← C+1.
  - signal == L: C ← 0. A glitch shorter than FILTER_DEPTH cycles restarts the count and produces no pulse.
- C never exceeds FILTER_DEPTH-1, so there is no wrap-around. For FILTER_DEPTH=1, C is constant 0 and accept = (signal != L).
- Channels are fully independent. Simultaneous transitions on several channels each pulse in their own accept cycle.
- A pulse fires only on a transition of the filtered level L. A bounce that returns to L before acceptance is invisible.

## Timing
- Reset values: level = {WIDTH{RESET_LEVEL}}. All pulse outputs are 0 while reset=1, regardless of signal.
- Pulse latency: signal changes before rising edge k, and the new value is held in the cycles ending at edges k..k+FILTER_DEPTH-1.
  - The pulse is asserted combinationally during the cycle ending at edge k+FILTER_DEPTH-1.
  - The bench samples it at that edge.
  - For FILTER_DEPTH=1, the pulse is visible at the first posedge after the change.
- level updates at the same edge the pulse is sampled, so it is visible one cycle after the pulse.
- Pulse width is exactly one cycle per accepted transition. A channel toggling every cycle with FILTER_DEPTH=1 pulses every cycle.
- Reset mid-filter: C is cleared, L ← RESET_LEVEL, and no pulse is emitted in the reset cycle.
  - After release, a signal that differs from RESET_LEVEL starts a fresh FILTER_DEPTH count.
- Released from reset with signal != RESET_LEVEL: this counts as a transition. The pulse comes after FILTER_DEPTH cycles.

## Test plan
- Reset state (WIDTH=4, RESET_LEVEL=0, signal=4'hF held through reset): all pulses 0 during reset. level=0 at the first edge after release.
- Baseline equivalence (WIDTH=1, FILTER_DEPTH=1, EDGE_MODE=2):
  - Signal 0→1 at negedge: edge_pulse=1 and rising_pulse=1 at the next posedge, 0 at the following one.
  - Same for 1→0 with falling_pulse.
  - 100 consecutive toggles: edge_pulse=1 every cycle.
- Filtering (FILTER_DEPTH=4):
  - High for 3 cycles, then low: no pulse, level stays 0.
  - High for 4 cycles: rising_pulse=1 exactly at the 4th posedge, level=1 from the 5th.
- Mode selection (EDGE_MODE=0 and 1, FILTER_DEPTH=1):
  - Full 0→1→0 sequence: edge_pulse fires only on the rising (mode 0) or only on the falling (mode 1) edge.
  - rising_pulse and falling_pulse are unaffected by mode.
- Channel independence and reset mid-filter (WIDTH=8, FILTER_DEPTH=3):
  - Channels 0 and 5 rise together; both pulse at the 3rd posedge, others stay 0.
  - Assert reset after 2 stable cycles on channel 2: no pulse. After release, channel 2 pulses 3 cycles later.
- Random (WIDTH=4, FILTER_DEPTH=2, 1000 cycles, $urandom per channel):
  - A reference model of L and C predicts every pulse and level bit.
  - Any mismatch, checked with !==, is an error.

Source files
------------

// File: rtl/filtered_edge_detector_if.sv
// Channel bundle for filtered_edge_detector.
// Ports (signals):
//   signal        raw channel inputs, driven by the source side
//   level         filtered level per channel
//   rising_pulse  accepted 0->1 transition, one cycle
//   falling_pulse accepted 1->0 transition, one cycle
//   edge_pulse    rising and/or falling pulse, selected by the detector's EDGE_MODE
// Modports: master = source/observer side, slave = detector side.
interface filtered_edge_detector_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] signal;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rising_pulse;
  logic [WIDTH-1:0] falling_pulse;
  logic [WIDTH-1:0] edge_pulse;

  modport master (
    output signal,
    input  level,
    input  rising_pulse,
    input  falling_pulse,
    input  edge_pulse
  );

  modport slave (
    input  signal,
    output level,
    output rising_pulse,
    output falling_pulse,
    output edge_pulse
  );
endinterface

// File: rtl/filtered_edge_detector.sv
// Multi-channel edge detector with per-channel glitch filtering.
// Each channel keeps a filtered level; a change on the input is accepted only after it has
// differed from that level for FILTER_DEPTH consecutive samples, producing a one-cycle pulse.
// Ports:
//   clock  single clock, rising edge
//   reset  synchronous, active-high
//   bus    filtered_edge_detector_if.slave: signal in; level, rising/falling/edge pulses out
module filtered_edge_detector #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned FILTER_DEPTH = 1,
  parameter int unsigned EDGE_MODE    = 2,
  parameter bit          RESET_LEVEL  = 1'b0
) (
  input logic                     clock,
  input logic                     reset,
  filtered_edge_detector_if.slave bus
);

  localparam int unsigned CountWidth = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam logic [CountWidth-1:0] CountMax = CountWidth'(FILTER_DEPTH - 1);

  logic [WIDTH-1:0]      level_q;
  logic [WIDTH-1:0]      level_d;
  logic [CountWidth-1:0] count_q [WIDTH];
  logic [CountWidth-1:0] count_d [WIDTH];
  logic [WIDTH-1:0]      differ;
  logic [WIDTH-1:0]      accept;
  logic [WIDTH-1:0]      rise;
  logic [WIDTH-1:0]      fall;

  assign differ = bus.signal ^ level_q;

  // Acceptance is masked by reset so no pulse escapes during the reset cycle.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = differ[i] && (count_q[i] == CountMax) && !reset;
    end
  end

  assign rise = accept & bus.signal;
  assign fall = accept & ~bus.signal;

  // The count saturates at CountMax through acceptance, so it never wraps.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < WIDTH; i++) begin
      count_d[i] = count_q[i];
      if (accept[i]) begin
        level_d[i] = bus.signal[i];
        count_d[i] = '0;
      end else if (differ[i]) begin
        count_d[i] = count_q[i] + CountWidth'(1);
      end else begin
        count_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= {WIDTH{RESET_LEVEL}};
      for (int i = 0; i < WIDTH; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < WIDTH; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  assign bus.level         = level_q;
  assign bus.rising_pulse  = rise;
  assign bus.falling_pulse = fall;

  // Unknown modes fall back to both edges.
  if (EDGE_MODE == 0) begin : g_edge_rise
    assign bus.edge_pulse = rise;
  end else if (EDGE_MODE == 1) begin : g_edge_fall
    assign bus.edge_pulse = fall;
  end else begin : g_edge_both
    assign bus.edge_pulse = rise | fall;
  end

endmodule

// File: tb/tb_filtered_edge_detector.sv
// Scoreboard bench for filtered_edge_detector. Six instances cover the parameter corners;
// the stimulus side pushes expected outputs, a monitor pops and compares each cycle.
module tb_filtered_edge_detector;

  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  filtered_edge_detector_if #(.WIDTH(1)) bus0 ();
  filtered_edge_detector_if #(.WIDTH(4)) bus1 ();
  filtered_edge_detector_if #(.WIDTH(1)) bus2 ();
  filtered_edge_detector_if #(.WIDTH(1)) bus3 ();
  filtered_edge_detector_if #(.WIDTH(8)) bus4 ();
  filtered_edge_detector_if #(.WIDTH(4)) bus5 ();

  filtered_edge_detector #(.WIDTH(1), .FILTER_DEPTH(1), .EDGE_MODE(2), .RESET_LEVEL(1'b0))
    u_base (.clock(clock), .reset(reset), .bus(bus0));
  filtered_edge_detector #(.WIDTH(4), .FILTER_DEPTH(4), .EDGE_MODE(2), .RESET_LEVEL(1'b0))
    u_filt (.clock(clock), .reset(reset), .bus(bus1));
  filtered_edge_detector #(.WIDTH(1), .FILTER_DEPTH(1), .EDGE_MODE(0), .RESET_LEVEL(1'b0))
    u_rise (.clock(clock), .reset(reset), .bus(bus2));
  filtered_edge_detector #(.WIDTH(1), .FILTER_DEPTH(1), .EDGE_MODE(1), .RESET_LEVEL(1'b0))
    u_fall (.clock(clock), .reset(reset), .bus(bus3));
  filtered_edge_detector #(.WIDTH(8), .FILTER_DEPTH(3), .EDGE_MODE(2), .RESET_LEVEL(1'b0))
    u_wide (.clock(clock), .reset(reset), .bus(bus4));
  filtered_edge_detector #(.WIDTH(4), .FILTER_DEPTH(2), .EDGE_MODE(2), .RESET_LEVEL(1'b0))
    u_rand (.clock(clock), .reset(reset), .bus(bus5));

  logic [7:0] obs_lvl [6];
  logic [7:0] obs_ris [6];
  logic [7:0] obs_fal [6];
  logic [7:0] obs_edg [6];

  assign obs_lvl[0] = 8'(bus0.level);
  assign obs_ris[0] = 8'(bus0.rising_pulse);
  assign obs_fal[0] = 8'(bus0.falling_pulse);
  assign obs_edg[0] = 8'(bus0.edge_pulse);
  assign obs_lvl[1] = 8'(bus1.level);
  assign obs_ris[1] = 8'(bus1.rising_pulse);
  assign obs_fal[1] = 8'(bus1.falling_pulse);
  assign obs_edg[1] = 8'(bus1.edge_pulse);
  assign obs_lvl[2] = 8'(bus2.level);
  assign obs_ris[2] = 8'(bus2.rising_pulse);
  assign obs_fal[2] = 8'(bus2.falling_pulse);
  assign obs_edg[2] = 8'(bus2.edge_pulse);
  assign obs_lvl[3] = 8'(bus3.level);
  assign obs_ris[3] = 8'(bus3.rising_pulse);
  assign obs_fal[3] = 8'(bus3.falling_pulse);
  assign obs_edg[3] = 8'(bus3.edge_pulse);
  assign obs_lvl[4] = bus4.level;
  assign obs_ris[4] = bus4.rising_pulse;
  assign obs_fal[4] = bus4.falling_pulse;
  assign obs_edg[4] = bus4.edge_pulse;
  assign obs_lvl[5] = 8'(bus5.level);
  assign obs_ris[5] = 8'(bus5.rising_pulse);
  assign obs_fal[5] = 8'(bus5.falling_pulse);
  assign obs_edg[5] = 8'(bus5.edge_pulse);

  typedef struct {
    int         id;
    logic [7:0] lvl;
    logic [7:0] ris;
    logic [7:0] fal;
    logic [7:0] edg;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input int id, input logic [7:0] sig);
    case (id)
      0: bus0.signal = sig[0];
      1: bus1.signal = sig[3:0];
      2: bus2.signal = sig[0];
      3: bus3.signal = sig[0];
      4: bus4.signal = sig;
      default: bus5.signal = sig[3:0];
    endcase
  endtask

  // One cycle: drive at negedge, expected outputs are those seen before the next posedge.
  task automatic step(input int id, input logic rst, input logic [7:0] sig,
                      input logic [7:0] lvl, input logic [7:0] ris, input logic [7:0] fal,
                      input logic [7:0] edg, input string name);
    exp_t e;
    @(negedge clock);
    reset = rst;
    drive(id, sig);
    e.id   = id;
    e.lvl  = lvl;
    e.ris  = ris;
    e.fal  = fal;
    e.edg  = edg;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clock);
      #2;
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (obs_lvl[e.id] !== e.lvl || obs_ris[e.id] !== e.ris ||
            obs_fal[e.id] !== e.fal || obs_edg[e.id] !== e.edg) begin
          errors++;
          $display("FAIL %s dut%0d: got level=%h rise=%h fall=%h edge=%h, want level=%h rise=%h fall=%h edge=%h",
                   e.name, e.id, obs_lvl[e.id], obs_ris[e.id], obs_fal[e.id], obs_edg[e.id],
                   e.lvl, e.ris, e.fal, e.edg);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] m_l;
    logic [3:0] m_c;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] acc;
    logic       rst_r;
    logic [7:0] t;

    reset       = 1'b1;
    bus0.signal = '0;
    bus1.signal = 4'hF;
    bus2.signal = '0;
    bus3.signal = '0;
    bus4.signal = '0;
    bus5.signal = '0;

    // Reset held with inputs high, then release: counts as a transition after 4 cycles.
    step(1, 1'b1, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, "reset_hold0");
    step(1, 1'b1, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, "reset_hold1");
    step(1, 1'b0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, "release_c0");
    step(1, 1'b0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, "release_c1");
    step(1, 1'b0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, "release_c2");
    step(1, 1'b0, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'h0F, "release_accept");
    step(1, 1'b0, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, "release_level");
    // Return all channels to 0 through the filter.
    step(1, 1'b0, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, "fall_c0");
    step(1, 1'b0, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, "fall_c1");
    step(1, 1'b0, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, "fall_c2");
    step(1, 1'b0, 8'h00, 8'h0F, 8'h00, 8'h0F, 8'h0F, "fall_accept");
    step(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "fall_level");
    // Three-cycle glitch on channel 0 is rejected.
    step(1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, "glitch_c0");
    step(1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, "glitch_c1");
    step(1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, "glitch_c2");
    step(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "glitch_back");
    step(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "glitch_level");
    // Four-cycle high is accepted at the 4th edge.
    step(1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, "hold_c0");
    step(1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, "hold_c1");
    step(1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, "hold_c2");
    step(1, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, "hold_accept");
    step(1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, "hold_level");

    // Baseline any-edge detector.
    step(0, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, "base_rise");
    step(0, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, "base_rise_end");
    step(0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, "base_fall");
    step(0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "base_fall_end");
    for (int i = 0; i < 100; i++) begin
      t = (i % 2 == 0) ? 8'h01 : 8'h00;
      step(0, 1'b0, t, t ^ 8'h01, t, t ^ 8'h01, 8'h01, "toggle");
    end

    // Edge mode 0: edge_pulse only on rising.
    step(2, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, "mode0_rise");
    step(2, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, "mode0_hold");
    step(2, 1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, "mode0_fall");
    step(2, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "mode0_idle");
    // Edge mode 1: edge_pulse only on falling.
    step(3, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, "mode1_rise");
    step(3, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, "mode1_hold");
    step(3, 1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, "mode1_fall");
    step(3, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "mode1_idle");

    // Channels 0 and 5 together, depth 3.
    step(4, 1'b0, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, "pair_c0");
    step(4, 1'b0, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, "pair_c1");
    step(4, 1'b0, 8'h21, 8'h00, 8'h21, 8'h00, 8'h21, "pair_accept");
    step(4, 1'b0, 8'h21, 8'h21, 8'h00, 8'h00, 8'h00, "pair_level");
    // Channel 2 interrupted by reset at what would be its accept cycle.
    step(4, 1'b0, 8'h25, 8'h21, 8'h00, 8'h00, 8'h00, "mid_c0");
    step(4, 1'b0, 8'h25, 8'h21, 8'h00, 8'h00, 8'h00, "mid_c1");
    step(4, 1'b1, 8'h25, 8'h21, 8'h00, 8'h00, 8'h00, "mid_reset");
    step(4, 1'b0, 8'h25, 8'h00, 8'h00, 8'h00, 8'h00, "post_c0");
    step(4, 1'b0, 8'h25, 8'h00, 8'h00, 8'h00, 8'h00, "post_c1");
    step(4, 1'b0, 8'h25, 8'h00, 8'h25, 8'h00, 8'h25, "post_accept");
    step(4, 1'b0, 8'h25, 8'h25, 8'h00, 8'h00, 8'h00, "post_level");

    // Random traffic against a reference model of L and C (depth 2, so C is one bit).
    m_l = 4'h0;
    m_c = 4'h0;
    for (int n = 0; n < 1000; n++) begin
      rst_r = ($urandom_range(0, 49) == 0);
      s     = 4'($urandom);
      acc   = (s ^ m_l) & m_c & {4{~rst_r}};
      r     = acc & s;
      f     = acc & ~s;
      step(5, rst_r, {4'h0, s}, {4'h0, m_l}, {4'h0, r}, {4'h0, f}, {4'h0, r | f}, "random");
      if (rst_r) begin
        m_l = 4'h0;
        m_c = 4'h0;
      end else begin
        for (int ch = 0; ch < 4; ch++) begin
          if (acc[ch]) begin
            m_l[ch] = s[ch];
            m_c[ch] = 1'b0;
          end else begin
            m_c[ch] = s[ch] ^ m_l[ch];
          end
        end
      end
    end

    @(negedge clock);
    @(negedge clock);
    #4;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
